fir_stream_ctrl: RTL and testbench
==================================

# fir_stream_ctrl

Sequencing controller for the multi-cycle `myFIR` filter core. It accepts 16-bit samples from an upstream valid/ready stream and issues each one to the FIR as a single-cycle `inputValid` pulse. It then waits for the FIR's `outputValid` and stores each 38-bit result in a small output FIFO that drains to a downstream valid/ready stream. It also supervises the FIR with a watchdog timeout and keeps a result counter.

## Interface
Parameters:
- `IN_W`, 16, sample width; matches FIR input width.
- `OUT_W`, 38, result width; matches FIR output width.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255, maximum WAIT cycles for a FIR result; 1..255.

Ports (reset is asynchronous and active-low):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: controller accepts a sample this cycle.
- `s_data` in IN_W: upstream sample.
- `fir_in_valid` out 1: one-cycle pulse to FIR `inputValid`.
- `fir_in_data` out IN_W: sample to FIR `FIR_input`; held stable from ISSUE until the controller re-enters IDLE.
- `fir_out_valid` in 1: FIR `outputValid`.
- `fir_out_data` in OUT_W: FIR `FIR_output`.
- `m_valid` out 1: FIFO head valid.
- `m_ready` in 1: downstream consumes the head.
- `m_data` out OUT_W: FIFO head.
- `busy` out 1: FSM is not in IDLE.
- `timeout_err` out 1: sticky flag, set on a watchdog expiry.
- `err_clr` in 1: synchronous clear of `timeout_err`.
- `result_count` out 16: number of FIFO pushes; wraps at 16'hFFFF→0.

## Operation
FSM states are IDLE, ISSUE and WAIT.
- **IDLE**
  - `s_ready` = (fifo_count < FIFO_DEPTH).
  - On `s_valid && s_ready`, latch `s_data` into the hold register and go to ISSUE.
  - Reserving a FIFO slot at admission guarantees the later push never overflows.
- **ISSUE**
  - `fir_in_valid` = 1 for exactly this cycle; `fir_in_data` = hold register.
  - Clear the timer and go to WAIT unconditionally.
- **WAIT**
  - The timer increments each cycle.
  - If `fir_out_valid` = 1: push `fir_out_data`, increment `result_count`, go to IDLE.
  - Else if timer == TIMEOUT-1: set `timeout_err`, go to IDLE, push nothing.
  - If `fir_out_valid` and expiry occur in the same cycle, valid wins and no error is flagged.
- `fir_out_valid` outside WAIT is ignored: no push, no state change.
- **FIFO**
  - Circular buffer with read/write pointers and count.
  - `m_valid` = count != 0; `m_data` = head entry.
  - Pop on `m_valid && m_ready`.
  - A simultaneous push and pop leaves count unchanged and preserves data order.
- **`timeout_err`**
  - Sets on expiry and stays set until `err_clr` or reset.
  - If set and clear occur in the same cycle, set wins.
- `s_ready` is 0 in ISSUE and WAIT: only one sample is in flight.

## Timing
- **Reset values** (asynchronous, immediate on `rst` = 0):
  - State = IDLE.
  - `s_ready` = 1 (FIFO empty).
  - `fir_in_valid`, `m_valid`, `busy`, `timeout_err` = 0.
  - `result_count`, `fir_in_data`, FIFO pointers and count = 0.
- **Reset mid-operation:** any in-flight sample and all FIFO contents are discarded. The first sample after reset release is accepted on the first rising edge with `s_valid` = 1.
- **Latency:**
  - Accept at edge 0; `fir_in_valid` high during cycle 1.
  - For a FIR that raises `outputValid` L cycles after `inputValid` (L ≥ 1), the push happens at that edge and `m_valid` rises the next cycle.
  - Input-to-`m_valid` latency = L+2 cycles.
- **Throughput:** one sample per L+2 cycles (IDLE, ISSUE, L WAIT cycles), provided the FIFO is not full.
- **Timeout:** WAIT lasts at most TIMEOUT cycles; `timeout_err` is visible the cycle after expiry, together with `busy` = 0.
- All outputs are registered except `s_ready`, `m_valid` and `m_data`, which decode directly from state and FIFO registers with no input-to-output combinational path.

## Test plan
- **Single sample:** reset, then drive `s_data` = 16'h0005. The FIR model returns 38'h00_0000_0019 with L = 3 → exactly one `fir_in_valid` pulse; `m_valid` 5 cycles after accept; `m_data` = 38'h19; `result_count` = 1.
- **Back-pressure:** hold `m_ready` = 0 and stream 6 samples with L = 3 → 4 results buffered, then `s_ready` = 0. Release `m_ready` → results drain in order and the remaining 2 samples complete; `result_count` = 6.
- **Timeout:** TIMEOUT = 8 and the FIR never responds → `timeout_err` = 1 after 8 WAIT cycles; `busy` = 0; no push. Assert `err_clr` → flag clears. The next sample processes normally.
- **Boundary race:** `fir_out_valid` arrives on the last WAIT cycle (timer = TIMEOUT-1) → result pushed, `timeout_err` stays 0. Separately, `fir_out_valid` asserted during IDLE → ignored; count unchanged.
- **Simultaneous push/pop:** FIFO holds 3 entries and a push and pop coincide → count stays 3 and output order is preserved.
- **Reset mid-WAIT:** assert `rst` = 0 while in WAIT with 2 entries in the FIFO → `m_valid` = 0, `s_ready` = 1, `result_count` = 0 immediately. A late `fir_out_valid` after release is ignored.

Source files
------------

// File: rtl/fir_stream_ctrl.sv
// Sequencing controller for the multi-cycle myFIR core: admits one sample at a
// time, pulses it into the FIR, collects the result into an output FIFO, and
// supervises the FIR with a watchdog.
module fir_stream_ctrl #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned OUT_W      = 38,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             fir_in_valid,
  output logic [IN_W-1:0]  fir_in_data,
  input  logic             fir_out_valid,
  input  logic [OUT_W-1:0] fir_out_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic [15:0]      result_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    hold_q, hold_d;
  logic [7:0]         timer_q, timer_d;
  logic               err_q, err_d;
  logic               fir_vld_q;
  logic               busy_q;
  logic [15:0]        rcnt_q, rcnt_d;

  logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               push;
  logic               pop;
  logic               expire;

  // Admission requires a free slot, which reserves room for the eventual push.
  assign s_ready = (state_q == S_IDLE) && (cnt_q != DEPTH_C);
  assign m_valid = (cnt_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    push    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready) begin
          hold_d  = s_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (fir_out_valid) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (expire) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rcnt_d   = rcnt_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Registered outputs are loaded from next-state so they align with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      fir_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      rcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      fir_vld_q <= (state_d == S_ISSUE);
      busy_q    <= (state_d != S_IDLE);
      rcnt_q    <= rcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fir_out_data;
    end
  end

  assign fir_in_valid = fir_vld_q;
  assign fir_in_data  = hold_q;
  assign busy         = busy_q;
  assign timeout_err  = err_q;
  assign result_count = rcnt_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a fixed-latency FIR model (result = 5*x)
// and a manual override path for boundary stimulus.
module tb_fir_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        fir_in_valid;
  logic [15:0] fir_in_data;
  logic        fir_out_valid;
  logic [37:0] fir_out_data;
  logic        m_valid;
  logic        m_ready;
  logic [37:0] m_data;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;
  logic [15:0] result_count;

  logic        fir_en;
  int          fir_lat;
  int          mdl_cnt;
  logic        mdl_valid;
  logic [37:0] mdl_data;
  logic        man_valid;
  logic [37:0] man_data;

  int n_chk;
  int n_pass;

  fir_stream_ctrl #(
    .IN_W      (16),
    .OUT_W     (38),
    .FIFO_DEPTH(4),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .fir_in_valid (fir_in_valid),
    .fir_in_data  (fir_in_data),
    .fir_out_valid(fir_out_valid),
    .fir_out_data (fir_out_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .result_count (result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fir_out_valid = mdl_valid | man_valid;
  assign fir_out_data  = man_valid ? man_data : mdl_data;

  // FIR model: outputValid is high L cycles after the inputValid cycle.
  initial begin
    mdl_cnt   = 0;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mdl_valid = 1'b0;
      if (mdl_cnt != 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) mdl_valid = 1'b1;
      end
      if (fir_in_valid === 1'b1 && fir_en) begin
        mdl_cnt  = fir_lat;
        mdl_data = {22'b0, fir_in_data} * 38'd5;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; err_clr = 1'b0;
    man_valid = 1'b0; man_data = '0; fir_en = 1'b1; fir_lat = 3;
    #3;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b exp 1", s_ready); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b exp 0", m_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (fir_in_valid !== 1'b0) $display("FAIL rst_fir_in_valid: got %b exp 0", fir_in_valid); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); else n_pass++;
    n_chk++; if (result_count !== 16'd0) $display("FAIL rst_result_count: got %0d exp 0", result_count); else n_pass++;
    n_chk++; if (fir_in_data !== 16'd0) $display("FAIL rst_fir_in_data: got %h exp 0", fir_in_data); else n_pass++;
    tick;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single;
    int pulses;
    s_valid = 1'b1; s_data = 16'h0005;
    tick;
    s_valid = 1'b0;
    pulses = 0;
    if (fir_in_valid === 1'b1) pulses++;
    n_chk++; if (fir_in_data !== 16'h0005) $display("FAIL single_fir_in_data: got %h exp 0005", fir_in_data); else n_pass++;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL single_s_ready_issue: got %b exp 0", s_ready); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b exp 1", busy); else n_pass++;
    for (int c = 2; c <= 4; c++) begin
      tick;
      if (fir_in_valid === 1'b1) pulses++;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL single_m_valid_early_c%0d: got %b exp 0", c, m_valid); else n_pass++;
    end
    tick;
    n_chk++; if (pulses != 1) $display("FAIL single_pulses: got %0d exp 1", pulses); else n_pass++;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL single_m_valid: got %b exp 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== 38'h19) $display("FAIL single_m_data: got %h exp 19", m_data); else n_pass++;
    n_chk++; if (result_count !== 16'd1) $display("FAIL single_result_count: got %0d exp 1", result_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_done: got %b exp 0", busy); else n_pass++;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL single_pop: got %b exp 0", m_valid); else n_pass++;
  endtask

  task automatic test_back_pressure;
    int   acc_n;
    int   out_n;
    logic acc;
    logic pop;
    acc_n = 0; out_n = 0;
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'd1;
    for (int cyc = 0; cyc < 150 && !(acc_n == 6 && out_n == 6); cyc++) begin
      if (cyc == 40) begin
        n_chk++; if (acc_n != 4) $display("FAIL bp_accepted_full: got %0d exp 4", acc_n); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_full: got %b exp 0", s_ready); else n_pass++;
        n_chk++; if (result_count !== 16'd5) $display("FAIL bp_count_full: got %0d exp 5", result_count); else n_pass++;
        m_ready = 1'b1;
      end
      acc = s_valid && s_ready;
      pop = m_valid && m_ready;
      if (pop) begin
        n_chk++;
        if (m_data !== 38'((out_n + 1) * 5))
          $display("FAIL bp_order_%0d: got %h exp %h", out_n, m_data, 38'((out_n + 1) * 5));
        else n_pass++;
        out_n++;
      end
      tick;
      if (acc) begin
        acc_n++;
        s_data = 16'(acc_n + 1);
        if (acc_n == 6) s_valid = 1'b0;
      end
    end
    m_ready = 1'b0; s_valid = 1'b0;
    n_chk++; if (out_n != 6) $display("FAIL bp_drained: got %0d exp 6", out_n); else n_pass++;
    n_chk++; if (result_count !== 16'd7) $display("FAIL bp_result_count: got %0d exp 7", result_count); else n_pass++;
  endtask

  task automatic test_timeout;
    fir_en = 1'b0;
    s_valid = 1'b1; s_data = 16'd7;
    tick;
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    n_chk++; if (busy !== 1'b1) $display("FAIL tmo_busy_last_wait: got %b exp 1", busy); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_err_early: got %b exp 0", timeout_err); else n_pass++;
    tick;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_set: got %b exp 1", timeout_err); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL tmo_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL tmo_no_push: got %b exp 0", m_valid); else n_pass++;
    n_chk++; if (result_count !== 16'd7) $display("FAIL tmo_count: got %0d exp 7", result_count); else n_pass++;
    tick;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b exp 1", timeout_err); else n_pass++;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_clear: got %b exp 0", timeout_err); else n_pass++;
    fir_en = 1'b1;
    s_valid = 1'b1; s_data = 16'd2;
    tick;
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL tmo_next_valid: got %b exp 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== 38'd10) $display("FAIL tmo_next_data: got %h exp a", m_data); else n_pass++;
    n_chk++; if (result_count !== 16'd8) $display("FAIL tmo_next_count: got %0d exp 8", result_count); else n_pass++;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  task automatic test_boundary_race;
    fir_en = 1'b0;
    s_valid = 1'b1; s_data = 16'd3;
    tick;
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    man_valid = 1'b1; man_data = 38'h3F;
    tick;
    man_valid = 1'b0;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL race_pushed: got %b exp 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== 38'h3F) $display("FAIL race_data: got %h exp 3f", m_data); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL race_no_err: got %b exp 0", timeout_err); else n_pass++;
    n_chk++; if (result_count !== 16'd9) $display("FAIL race_count: got %0d exp 9", result_count); else n_pass++;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    man_valid = 1'b1; man_data = 38'h55;
    tick;
    tick;
    man_valid = 1'b0;
    tick;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL idle_ignore_valid: got %b exp 0", m_valid); else n_pass++;
    n_chk++; if (result_count !== 16'd9) $display("FAIL idle_ignore_count: got %0d exp 9", result_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_ignore_busy: got %b exp 0", busy); else n_pass++;
    fir_en = 1'b1;
  endtask

  task automatic test_simul_push_pop;
    for (int j = 0; j < 3; j++) begin
      s_valid = 1'b1; s_data = 16'(10 + j);
      tick;
      s_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick;
    end
    n_chk++; if (result_count !== 16'd12) $display("FAIL simul_fill_count: got %0d exp 12", result_count); else n_pass++;
    s_valid = 1'b1; s_data = 16'd13;
    tick;
    s_valid = 1'b0;
    tick; tick; tick;
    m_ready = 1'b1;
    n_chk++; if (m_data !== 38'd50) $display("FAIL simul_head: got %0d exp 50", m_data); else n_pass++;
    tick;
    m_ready = 1'b0;
    n_chk++; if (m_data !== 38'd55) $display("FAIL simul_next: got %0d exp 55", m_data); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL simul_s_ready: got %b exp 1", s_ready); else n_pass++;
    n_chk++; if (result_count !== 16'd13) $display("FAIL simul_count: got %0d exp 13", result_count); else n_pass++;
    m_ready = 1'b1;
    tick;
    n_chk++; if (m_data !== 38'd60) $display("FAIL simul_order_60: got %0d exp 60", m_data); else n_pass++;
    tick;
    n_chk++; if (m_data !== 38'd65) $display("FAIL simul_order_65: got %0d exp 65", m_data); else n_pass++;
    tick;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL simul_empty: got %b exp 0", m_valid); else n_pass++;
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    for (int j = 0; j < 2; j++) begin
      s_valid = 1'b1; s_data = 16'(20 + j);
      tick;
      s_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick;
    end
    s_valid = 1'b1; s_data = 16'd22;
    tick;
    s_valid = 1'b0;
    tick;
    n_chk++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b exp 1", busy); else n_pass++;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL rmid_m_valid_before: got %b exp 1", m_valid); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %b exp 0", m_valid); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready: got %b exp 1", s_ready); else n_pass++;
    n_chk++; if (result_count !== 16'd0) $display("FAIL rmid_count: got %0d exp 0", result_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b exp 0", busy); else n_pass++;
    tick;
    rst = 1'b1;
    s_valid = 1'b1; s_data = 16'd4;
    tick;
    s_valid = 1'b0;
    n_chk++; if (fir_in_valid !== 1'b1) $display("FAIL rmid_first_accept: got %b exp 1", fir_in_valid); else n_pass++;
    n_chk++; if (fir_in_data !== 16'd4) $display("FAIL rmid_first_data: got %h exp 4", fir_in_data); else n_pass++;
    tick;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rmid_late_ignored: got %b exp 0", m_valid); else n_pass++;
    n_chk++; if (result_count !== 16'd0) $display("FAIL rmid_late_count: got %0d exp 0", result_count); else n_pass++;
    tick; tick; tick;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL rmid_after_valid: got %b exp 1", m_valid); else n_pass++;
    n_chk++; if (m_data !== 38'd20) $display("FAIL rmid_after_data: got %0d exp 20", m_data); else n_pass++;
    n_chk++; if (result_count !== 16'd1) $display("FAIL rmid_after_count: got %0d exp 1", result_count); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset;
    test_single;
    test_back_pressure;
    test_timeout;
    test_boundary_race;
    test_simul_push_pop;
    test_reset_mid_wait;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
